// File: rtl/ws_burst_arbiter_pkg.sv
// Shared types and constants for the weight-stationary burst arbiter.
// Latency: none (declarations only).
// Backpressure: not applicable.
package ws_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARB   = 2'd1,
        ST_SETUP = 2'd2,
        ST_XFER  = 2'd3
    } state_t;

    localparam logic RW_LOAD   = 1'b0;
    localparam logic RW_UNLOAD = 1'b1;

    // Ceiling log2 for elaboration-time width derivation.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/ws_burst_arbiter_if.sv
// Bundles the core request lines and the SRAM beat channel of the burst arbiter.
// Latency: none (wires only).
// Backpressure: xfer_ready from the SRAM side stalls beats presented with xfer_valid.
interface ws_burst_arbiter_if #(
    parameter int NUM_CORES = 4,
    parameter int ADDR_W    = 6,
    parameter int BURST_W   = 6
);
    logic [NUM_CORES-1:0] req_w;
    logic                 xfer_ready;
    logic [NUM_CORES-1:0] grant;
    logic [BURST_W-1:0]   burst;
    logic                 rw;
    logic [ADDR_W-1:0]    addr;
    logic                 xfer_valid;
    logic                 done;
    logic [NUM_CORES-1:0] phase;

    // Arbiter side: consumes requests and SRAM ready, drives the beat channel.
    modport master (
        input  req_w, xfer_ready,
        output grant, burst, rw, addr, xfer_valid, done, phase
    );

    // Core/SRAM side: drives requests and ready, observes the beat channel.
    modport slave (
        output req_w, xfer_ready,
        input  grant, burst, rw, addr, xfer_valid, done, phase
    );
endinterface

// File: rtl/ws_burst_arbiter_rr_picker.sv
// Combinational winner select: round-robin from ptr (RR=1) or highest index (RR=0).
// Latency: zero cycles, purely combinational.
// Backpressure: none; caller samples the result when it wants it.
module ws_rr_picker #(
    parameter int N  = 4,
    parameter bit RR = 1'b1,
    parameter int IW = ws_arb_pkg::clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  win_oh,
    output logic [IW-1:0] win_idx
);
    logic found;

    // Scan requests for the winner, then expand its index to one-hot.
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        if (RR) begin
            for (int i = 0; i < N; i++) begin
                if (!found && req[(int'(ptr) + i) % N]) begin
                    found   = 1'b1;
                    win_idx = IW'((int'(ptr) + i) % N);
                end
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (req[i]) begin
                    found   = 1'b1;
                    win_idx = IW'(i);
                end
            end
        end
        win_oh = found ? ({{(N-1){1'b0}}, 1'b1} << win_idx) : '0;
    end

endmodule

// File: rtl/ws_burst_arbiter.sv
// Grants one core a weight-buffer burst, alternating LOAD/UNLOAD per core, with windowed addresses.
// Latency: req sampled at E0, grant after E1, first beat after E2; done one cycle after last accept.
// Backpressure: beats hold addr/rw while xfer_ready is low; requests are ignored outside IDLE.
module ws_burst_arbiter
    import ws_arb_pkg::*;
#(
    parameter int NUM_CORES  = 4,
    parameter int ADDR_W     = 6,
    parameter int BURST_W    = 6,
    parameter int LOAD_LEN   = 16,
    parameter int UNLOAD_LEN = 16,
    parameter bit RR_MODE    = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    ws_burst_arbiter_if.master bus
);
    localparam int IDX_W = clog2(NUM_CORES);
    localparam int OFF_W = ADDR_W - IDX_W;

    state_t               state;
    state_t               state_nxt;
    logic [NUM_CORES-1:0] req_reg;
    logic [IDX_W-1:0]     rr_ptr;
    logic [IDX_W-1:0]     idx;
    logic [BURST_W-1:0]   beat;

    logic [NUM_CORES-1:0] grant_q;
    logic [BURST_W-1:0]   burst_q;
    logic                 rw_q;
    logic [ADDR_W-1:0]    addr_q;
    logic                 vld_q;
    logic                 done_q;
    logic [NUM_CORES-1:0] phase_q;

    logic [NUM_CORES-1:0] pick_oh;
    logic [IDX_W-1:0]     pick_idx;

    logic sample_req;
    logic do_arb;
    logic do_setup;
    logic beat_acc;
    logic last_beat;

    ws_rr_picker #(
        .N  (NUM_CORES),
        .RR (RR_MODE),
        .IW (IDX_W)
    ) u_picker (
        .req     (req_reg),
        .ptr     (rr_ptr),
        .win_oh  (pick_oh),
        .win_idx (pick_idx)
    );

    // State register; reset abandons any in-flight burst.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: one cycle each in ARB and SETUP, XFER until the last beat is accepted.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (|bus.req_w) state_nxt = ST_ARB;
            ST_ARB:   state_nxt = ST_SETUP;
            ST_SETUP: state_nxt = ST_XFER;
            ST_XFER:  if (last_beat) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Per-state control strobes that steer the datapath registers.
    always_comb begin
        sample_req = (state == ST_IDLE) && (|bus.req_w);
        do_arb     = (state == ST_ARB);
        do_setup   = (state == ST_SETUP);
        beat_acc   = (state == ST_XFER) && vld_q && bus.xfer_ready;
        last_beat  = beat_acc && (beat == burst_q - 1'b1);
    end

    // Datapath: latch requests, register the winner, run the beat counter, flip phase on completion.
    always_ff @(posedge clk) begin
        if (reset) begin
            req_reg <= '0;
            rr_ptr  <= '0;
            idx     <= '0;
            beat    <= '0;
            grant_q <= '0;
            burst_q <= '0;
            rw_q    <= RW_LOAD;
            addr_q  <= '0;
            vld_q   <= 1'b0;
            done_q  <= 1'b0;
            phase_q <= '0;
        end else begin
            done_q <= 1'b0;
            if (sample_req) begin
                req_reg <= bus.req_w;
            end
            if (do_arb) begin
                grant_q <= pick_oh;
                idx     <= pick_idx;
                rr_ptr  <= (pick_idx == IDX_W'(NUM_CORES - 1)) ? '0 : pick_idx + 1'b1;
            end
            if (do_setup) begin
                burst_q <= phase_q[idx] ? BURST_W'(UNLOAD_LEN) : BURST_W'(LOAD_LEN);
                rw_q    <= phase_q[idx] ? RW_UNLOAD : RW_LOAD;
                addr_q  <= ADDR_W'(idx) << OFF_W;
                beat    <= '0;
                vld_q   <= 1'b1;
            end
            if (beat_acc) begin
                if (last_beat) begin
                    vld_q        <= 1'b0;
                    grant_q      <= '0;
                    burst_q      <= '0;
                    phase_q[idx] <= ~phase_q[idx];
                    done_q       <= 1'b1;
                end else begin
                    addr_q <= addr_q + 1'b1;
                    beat   <= beat + 1'b1;
                end
            end
        end
    end

    assign bus.grant      = grant_q;
    assign bus.burst      = burst_q;
    assign bus.rw         = rw_q;
    assign bus.addr       = addr_q;
    assign bus.xfer_valid = vld_q;
    assign bus.done       = done_q;
    assign bus.phase      = phase_q;

endmodule

// File: tb/tb_ws_burst_arbiter.sv
// Scoreboard bench for ws_burst_arbiter: round-robin DUT plus a fixed-priority DUT.
// Latency: checks grant/first-beat timing against the E0/E1/E2 schedule.
// Backpressure: drives a 1,0,0,1 ready pattern to exercise beat stalls.
module tb_ws_burst_arbiter;
    localparam int NC   = 4;
    localparam int AW   = 6;
    localparam int BW   = 6;
    localparam int LLEN = 16;
    localparam int ULEN = 12;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ws_burst_arbiter_if #(.NUM_CORES(NC), .ADDR_W(AW), .BURST_W(BW)) bus_a ();
    ws_burst_arbiter_if #(.NUM_CORES(NC), .ADDR_W(AW), .BURST_W(BW)) bus_b ();

    ws_burst_arbiter #(
        .NUM_CORES(NC), .ADDR_W(AW), .BURST_W(BW),
        .LOAD_LEN(LLEN), .UNLOAD_LEN(ULEN), .RR_MODE(1'b1)
    ) u_dut_rr (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    ws_burst_arbiter #(
        .NUM_CORES(NC), .ADDR_W(AW), .BURST_W(BW),
        .LOAD_LEN(LLEN), .UNLOAD_LEN(ULEN), .RR_MODE(1'b0)
    ) u_dut_fixed (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    typedef struct packed {
        logic [NC-1:0] g;
        logic          rw;
        logic [AW-1:0] addr;
        logic [BW-1:0] burst;
    } beat_t;

    beat_t         bq[$];
    logic [NC-1:0] dq[$];
    logic [NC-1:0] gq_b[$];

    int            checks = 0;
    int            errors = 0;
    int            acc_cnt = 0;
    int            rdy_cyc = 0;
    logic          ready_mode = 1'b0;
    logic [3:0]    rdy_pat = 4'b1001;
    logic [NC-1:0] phase_m = '0;
    logic [NC-1:0] grant_b_prev = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_grant"}, 32'(bus_a.grant), 0);
        chk({tag, "_burst"}, 32'(bus_a.burst), 0);
        chk({tag, "_rw"}, 32'(bus_a.rw), 0);
        chk({tag, "_addr"}, 32'(bus_a.addr), 0);
        chk({tag, "_valid"}, 32'(bus_a.xfer_valid), 0);
        chk({tag, "_done"}, 32'(bus_a.done), 0);
        chk({tag, "_phase"}, 32'(bus_a.phase), 0);
    endtask

    // Expected beats for one burst on 'core', using the bench's own phase model.
    task automatic push_burst(input int core);
        beat_t         e;
        logic          p;
        int            len;
        logic [NC-1:0] one;
        one = 1;
        p   = phase_m[core];
        len = p ? ULEN : LLEN;
        for (int k = 0; k < len; k++) begin
            e.g     = one << core;
            e.rw    = p;
            e.addr  = AW'(core * 16 + k);
            e.burst = BW'(len);
            bq.push_back(e);
        end
        phase_m[core] = ~p;
        dq.push_back(phase_m);
    endtask

    task automatic wait_done(input bit on_b, input string name);
        int n;
        bit seen;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 400) begin
            @(negedge clk);
            n++;
            seen = on_b ? bus_b.done : bus_a.done;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s: timeout, done never seen", name);
        end
    endtask

    task automatic issue(input logic [NC-1:0] req, input int core, input bit lat);
        logic [NC-1:0] one;
        one = 1;
        push_burst(core);
        @(posedge clk); #1 bus_a.req_w = req;
        @(posedge clk); #1 bus_a.req_w = '0;
        if (lat) begin
            chk("lat_e0_grant", 32'(bus_a.grant), 0);
            @(posedge clk); #1;
            chk("lat_e1_grant", 32'(bus_a.grant), 32'(one << core));
            chk("lat_e1_valid", 32'(bus_a.xfer_valid), 0);
            @(posedge clk); #1;
            chk("lat_e2_valid", 32'(bus_a.xfer_valid), 1);
            chk("lat_e2_addr", 32'(bus_a.addr), 32'(core * 16));
        end
        wait_done(1'b0, "done_rr");
    endtask

    // Ready driver: constant high, or the repeating 1,0,0,1 stall pattern.
    initial begin
        bus_a.xfer_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (ready_mode) begin
                bus_a.xfer_ready = rdy_pat[rdy_cyc % 4];
                rdy_cyc++;
            end else begin
                bus_a.xfer_ready = 1'b1;
            end
        end
    end

    // Monitor for the round-robin DUT: compares every presented beat and every done pulse.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            chk("grant_onehot0", 32'($onehot0(bus_a.grant)), 1);
            if (bus_a.xfer_valid) begin
                if (bq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL beat_unexpected: addr 0x%0h presented, none expected", bus_a.addr);
                end else begin
                    chk("beat_grant", 32'(bus_a.grant), 32'(bq[0].g));
                    chk("beat_rw", 32'(bus_a.rw), 32'(bq[0].rw));
                    chk("beat_addr", 32'(bus_a.addr), 32'(bq[0].addr));
                    chk("beat_burst", 32'(bus_a.burst), 32'(bq[0].burst));
                    if (bus_a.xfer_ready) begin
                        void'(bq.pop_front());
                        acc_cnt++;
                    end
                end
            end
            if (bus_a.done) begin
                chk("done_no_valid", 32'(bus_a.xfer_valid), 0);
                if (dq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL done_unexpected: done pulse with none expected");
                end else begin
                    chk("done_phase", 32'(bus_a.phase), 32'(dq[0]));
                    void'(dq.pop_front());
                end
            end
        end
    end

    // Monitor for the fixed-priority DUT: compares the grant at the start of each burst.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (bus_b.grant != '0 && grant_b_prev == '0) begin
                if (gq_b.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL fixed_unexpected: grant 0x%0h", bus_b.grant);
                end else begin
                    chk("fixed_grant", 32'(bus_b.grant), 32'(gq_b[0]));
                    void'(gq_b.pop_front());
                end
            end
            grant_b_prev = bus_b.grant;
        end
    end

    initial begin
        int a0;
        int n;
        bus_a.req_w      = 4'b1111;
        bus_b.req_w      = '0;
        bus_b.xfer_ready = 1'b1;

        // Reset held three cycles with all requests up.
        repeat (3) begin
            @(posedge clk); #1;
            chk_all_zero("rst");
        end
        reset       = 1'b0;
        bus_a.req_w = '0;
        @(posedge clk); #1;
        chk("post_rst_grant", 32'(bus_a.grant), 0);

        // Single core 2: LOAD then UNLOAD.
        issue(4'b0100, 2, 1'b1);
        issue(4'b0100, 2, 1'b0);

        // Fresh reset, then all requests held for five round-robin bursts.
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1 reset = 1'b0;
        phase_m = '0;
        push_burst(0);
        push_burst(1);
        push_burst(2);
        push_burst(3);
        push_burst(0);
        @(posedge clk); #1 bus_a.req_w = 4'b1111;
        repeat (4) wait_done(1'b0, "done_rr_hold");
        @(posedge clk); #1 bus_a.req_w = '0;
        wait_done(1'b0, "done_rr_hold_last");

        // Fixed priority: highest index wins every burst.
        repeat (3) gq_b.push_back(4'b1000);
        @(posedge clk); #1 bus_b.req_w = 4'b1111;
        repeat (2) wait_done(1'b1, "done_fixed");
        @(posedge clk); #1 bus_b.req_w = '0;
        wait_done(1'b1, "done_fixed_last");

        // Stalled LOAD burst on core 0.
        ready_mode = 1'b1;
        a0 = acc_cnt;
        issue(4'b0001, 0, 1'b0);
        ready_mode = 1'b0;
        chk("stall_beats", 32'(acc_cnt - a0), LLEN);

        // Request dropped after sampling; pointer wraps from core 3 back to core 0.
        issue(4'b1000, 3, 1'b0);
        issue(4'b1001, 0, 1'b0);

        // Reset while presenting beat 5 of a burst on core 1.
        push_burst(1);
        a0 = acc_cnt;
        @(posedge clk); #1 bus_a.req_w = 4'b0010;
        @(posedge clk); #1 bus_a.req_w = '0;
        n = 0;
        while (acc_cnt < a0 + 5 && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL abort_wait: timeout, beats seen %0d", acc_cnt - a0);
        end
        #1 reset = 1'b1;
        @(posedge clk); #1;
        chk_all_zero("abort");
        bq.delete();
        dq.delete();
        phase_m = '0;
        reset = 1'b0;
        repeat (4) @(posedge clk);
        issue(4'b0010, 1, 1'b1);

        repeat (5) @(posedge clk);
        chk("beat_queue_empty", 32'(bq.size()), 0);
        chk("done_queue_empty", 32'(dq.size()), 0);
        chk("fixed_queue_empty", 32'(gq_b.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
